// File: rtl/match_event_logger_pkg.sv
// Shared defaults, timestamp type and saturating-increment helper for the
// match event logger.
package match_event_logger_pkg;

  localparam int unsigned TS_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef logic [TS_W_DEF-1:0] ts_t;

  // Increments v unless it already equals the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - w);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/match_event_logger_sync_fifo.sv
// Synchronous FIFO with registered head data and registered full/empty flags.
// No fall-through: a push into an empty FIFO is visible one cycle later.
module sync_fifo #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign level      = count;
  assign rd_ptr_inc = rd_ptr + AW'(1);

  always_comb begin
    do_pop    = pop & ~empty;
    do_push   = push & (~full | do_pop);
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + ONE_LVL;
    end else if (do_pop && !do_push) begin
      count_nxt = count - ONE_LVL;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_LVL);
      empty <= (count_nxt == '0);
    end
  end

  // The head register must track the entry rd_ptr will point at after this
  // edge; when that slot is being written in the same cycle, bypass wr_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (clr) begin
      rd_data <= '0;
    end else if (do_pop) begin
      if (do_push && count == ONE_LVL) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= mem[rd_ptr_inc];
      end
    end else if (do_push && empty) begin
      rd_data <= wr_data;
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// Timestamps match pulses into a small FIFO drained by valid/ready, with
// saturating match/drop counters and a sticky overflow flag.
module match_event_logger
  import match_event_logger_pkg::*;
#(
  parameter int unsigned TS_W  = TS_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   match_in,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [TS_W-1:0]        evt_ts,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       match_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow
);

  logic [TS_W-1:0]  ts;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic [CNT_W-1:0] mc_inc;
  logic [CNT_W-1:0] dc_inc;

  // clr wins over both the incoming event and the pop of the same cycle.
  assign push      = match_in & ~clr;
  assign pop       = evt_ready & ~fifo_empty & ~clr;
  assign drop      = push & fifo_full & ~pop;
  assign evt_valid = ~fifo_empty;

  always_comb begin
    mc_inc = CNT_W'(sat_inc(32'(match_count), CNT_W));
    dc_inc = CNT_W'(sat_inc(32'(drop_count), CNT_W));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts <= '0;
    end else if (clr) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else if (clr) begin
      match_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) begin
        match_count <= mc_inc;
      end
      if (drop) begin
        drop_count <= dc_inc;
        overflow   <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .wr_data (ts),
    .rd_data (evt_ts),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

endmodule

// File: tb/tb_match_event_logger.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_match_event_logger;
  import match_event_logger_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int          MAXC  = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       match_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  ts_t        evt_ts;
  logic [2:0] level;
  logic [7:0] match_count;
  logic [7:0] drop_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  ts_t mq[$];
  ts_t m_ts = '0;
  int  m_mc = 0;
  int  m_dc = 0;
  bit  m_ov = 1'b0;

  always #5 clk = ~clk;

  match_event_logger #(
    .TS_W  (16),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .match_in    (match_in),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_ts      (evt_ts),
    .level       (level),
    .match_count (match_count),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a queue of timestamps plus plain integer counters.
  always @(posedge clk or negedge rst) begin
    int sz;
    bit popped;
    if (!rst) begin
      mq.delete();
      m_ts = '0; m_mc = 0; m_dc = 0; m_ov = 1'b0;
    end else if (clr) begin
      mq.delete();
      m_ts = '0; m_mc = 0; m_dc = 0; m_ov = 1'b0;
    end else begin
      sz = mq.size();
      popped = (sz > 0) && evt_ready;
      if (popped) void'(mq.pop_front());
      if (match_in) begin
        if (m_mc < MAXC) m_mc++;
        if (sz < DEPTH || popped) mq.push_back(m_ts);
        else begin
          if (m_dc < MAXC) m_dc++;
          m_ov = 1'b1;
        end
      end
      m_ts++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("m_valid", 32'(evt_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("m_head_ts", 32'(evt_ts), 32'(mq[0]));
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_match_count", 32'(match_count), 32'(m_mc));
      chk("m_drop_count", 32'(drop_count), 32'(m_dc));
      chk("m_overflow", 32'(overflow), 32'(m_ov));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ts(input ts_t t);
    int n;
    n = 0;
    while (m_ts != t && n < 70000) begin
      tick();
      n++;
    end
    chk("wait_ts_timeout", 32'(n < 70000), 32'd1);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_mc"}, 32'(match_count), 32'd0);
    chk({tag, "_dc"}, 32'(drop_count), 32'd0);
    chk({tag, "_ov"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk_zero("reset");
    chk("reset_ts", 32'(evt_ts), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single pulse at ts=5
    wait_ts(16'd5);
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
    chk("single_valid", 32'(evt_valid), 32'd1);
    chk("single_ts", 32'(evt_ts), 32'd5);
    chk("single_mc", 32'(match_count), 32'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("single_drained", 32'(evt_valid), 32'd0);

    // Five pulses into a four-deep FIFO with no consumer
    do_clr();
    match_in = 1'b1;
    repeat (5) tick();
    match_in = 1'b0;
    chk("full_level", 32'(level), 32'd4);
    chk("full_dc", 32'(drop_count), 32'd1);
    chk("full_ov", 32'(overflow), 32'd1);
    chk("full_mc", 32'(match_count), 32'd5);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_ts", 32'(evt_ts), 32'(i));
      tick();
    end
    evt_ready = 1'b0;
    chk("drain_empty", 32'(evt_valid), 32'd0);

    // Full FIFO with simultaneous push and pop: no drop
    do_clr();
    match_in = 1'b1;
    repeat (4) tick();
    evt_ready = 1'b1;
    tick();
    match_in = 1'b0;
    evt_ready = 1'b0;
    chk("pp_level", 32'(level), 32'd4);
    chk("pp_dc", 32'(drop_count), 32'd0);
    chk("pp_ov", 32'(overflow), 32'd0);
    evt_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("pp_ts", 32'(evt_ts), 32'(i));
      tick();
    end
    evt_ready = 1'b0;

    // Head held stable while not accepted
    do_clr();
    wait_ts(16'd7);
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(evt_valid), 32'd1);
      chk("hold_ts", 32'(evt_ts), 32'd7);
      tick();
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;

    // Counter saturation under sustained overflow
    do_clr();
    match_in = 1'b1;
    repeat (300) tick();
    match_in = 1'b0;
    chk("sat_mc", 32'(match_count), 32'd255);
    chk("sat_dc", 32'(drop_count), 32'd255);
    chk("sat_ov", 32'(overflow), 32'd1);
    chk("sat_level", 32'(level), 32'd4);

    // Timestamp wrap
    do_clr();
    wait_ts(16'hFFFF);
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
    tick();
    match_in = 1'b1;
    tick();
    match_in = 1'b0;
    chk("wrap_level", 32'(level), 32'd2);
    evt_ready = 1'b1;
    chk("wrap_ts0", 32'(evt_ts), 32'hFFFF);
    tick();
    chk("wrap_ts1", 32'(evt_ts), 32'h0001);
    tick();
    evt_ready = 1'b0;
    chk("wrap_empty", 32'(evt_valid), 32'd0);

    // clr coinciding with a match and a pop
    do_clr();
    match_in = 1'b1;
    repeat (3) tick();
    clr = 1'b1;
    evt_ready = 1'b1;
    tick();
    clr = 1'b0;
    match_in = 1'b0;
    evt_ready = 1'b0;
    chk_zero("clr");

    // Asynchronous reset mid-operation
    match_in = 1'b1;
    repeat (3) tick();
    match_in = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_zero("arst");
    @(posedge clk); #1;
    rst = 1'b1;
    chk("arst_rel_level", 32'(level), 32'd0);
    chk("arst_rel_valid", 32'(evt_valid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      match_in  = ($urandom_range(0, 2) == 0);
      evt_ready = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      clr       = ($urandom_range(0, 199) == 0);
      tick();
    end
    match_in  = 1'b0;
    evt_ready = 1'b0;
    clr       = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the serial `10010` sequence detector. It timestamps each one-cycle match pulse from the detector's registered output and buffers the timestamps in a small FIFO. Software or a downstream stage drains the FIFO through a valid/ready handshake. The block also keeps saturating match and drop counters and a sticky overflow flag, for status readout.

## Interface
Parameters:
- `TS_W`, 16: timestamp counter width.
- `DEPTH`, 4: FIFO entries. Must be a power of two and at least 2.
- `CNT_W`, 8: width of the match and drop counters.

Ports:
- `clk`, in, 1: clock. All state is updated on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `clr`, in, 1: synchronous clear of all state.
- `match_in`, in, 1: match pulse from the detector. Sampled every cycle.
- `evt_valid`, out, 1: the FIFO head is available.
- `evt_ready`, in, 1: the consumer accepts the head this cycle.
- `evt_ts`, out, `TS_W`: timestamp at the FIFO head.
- `level`, out, `$clog2(DEPTH)+1`: current FIFO occupancy.
- `match_count`, out, `CNT_W`: total matches seen. Saturating.
- `drop_count`, out, `CNT_W`: matches dropped because the FIFO was full. Saturating.
- `overflow`, out, 1: sticky. Set by the first drop.

## Operation
- Timestamp counter `ts`:
  - free-running; +1 every cycle; wraps from 2^TS_W−1 to 0;
  - no saturation.
- Push on `match_in`=1:
  - the current `ts` value, i.e. the cycle in which `match_in` is high, is written at the FIFO tail;
  - `match_count` increments on every `match_in`=1, whether or not the push is accepted; it holds at all-ones.
- Pop: when `evt_valid`=1 and `evt_ready`=1, the head is removed. `evt_ready` is ignored while `evt_valid`=0.
- FIFO full (`level`=DEPTH):
  - a push with no simultaneous pop is dropped; `drop_count` increments (saturating) and `overflow` is set;
  - a push with a simultaneous pop is accepted; `level` stays at DEPTH; no drop.
- FIFO empty: a pop cannot occur. A push makes `evt_valid`=1 in the next cycle. There is no fall-through.
- Simultaneous push and pop on a non-empty, non-full FIFO: `level` is unchanged.
- Handshake rules:
  - `evt_ts` is held stable while `evt_valid`=1 and `evt_ready`=0;
  - `evt_valid` drops only after a pop that empties the FIFO.
- `clr`=1:
  - resets `ts`, the FIFO pointers, `level`, both counters and `overflow` to 0;
  - takes priority over `match_in` and the pop in the same cycle; the event in that cycle is neither counted nor stored.
- Back-to-back `match_in` pulses are fully supported, even though the detector cannot produce pulses closer than 3 cycles apart.

## Timing
- Reset values (`rst`=0, asynchronous): `evt_valid`=0, `evt_ts`=0, `level`=0, `match_count`=0, `drop_count`=0, `overflow`=0, `ts`=0.
- Reset applied mid-operation discards the FIFO contents immediately. Operation resumes on the first clock edge after `rst` deasserts, with `ts`=0 in that cycle.
- Latency: `match_in` in cycle N gives `evt_valid`=1 and `evt_ts`=ts(N) in cycle N+1, if the FIFO was empty.
- Counters and `overflow` update at the edge that ends cycle N; they are visible in cycle N+1.
- Pop in cycle N: the next entry is presented in cycle N+1, or `evt_valid`=0 if the FIFO is now empty.
- All outputs are registered or driven directly from registers/RAM. No combinational path from `match_in` or `evt_ready` to any output.

## Structure
- The shared package holds:
  - the default values of `TS_W`, `DEPTH` and `CNT_W`;
  - a typedef `ts_t` for `logic [TS_W-1:0]`;
  - a saturating-increment function used for both counters.
- One sub-module, `sync_fifo`:
  - parameterised width and depth;
  - push/pop/full/empty/level ports;
  - registered read data.
- The top level contains the timestamp counter, the drop/count logic, `clr` handling and the handshake mapping onto `sync_fifo`.

## Test plan
- Reset, then a single `match_in` pulse at ts=5 → `evt_valid`=1 in the next cycle, `evt_ts`=5, `match_count`=1; with `evt_ready`=1, `evt_valid` returns to 0 one cycle later.
- Five pulses with `evt_ready`=0 and DEPTH=4 → `level`=4, `drop_count`=1, `overflow`=1, `match_count`=5; draining returns the first four timestamps in order.
- FIFO full, `match_in`=1 and `evt_ready`=1 in the same cycle → no drop; `level` stays 4; the new timestamp is appended at the tail.
- Hold `evt_ready`=0 for 10 cycles with one entry held → `evt_ts` unchanged and `evt_valid` stays 1 throughout.
- Run past ts=0xFFFF, pulse at 0xFFFF and again at 0x0001 → entries read back as 0xFFFF then 0x0001.
- `clr`=1 in the same cycle as `match_in`, with 3 entries queued → next cycle `level`=0, `evt_valid`=0, both counters 0, `overflow`=0. Repeat with `rst` asserted mid-operation → same result, applied asynchronously.
